clk_div_bank: RTL and testbench
===============================

Name: clk_div_bank

Overview:
- Parametrised, multi-channel successor to the single fixed-rate example counter.
- Driven by the MMCM-derived safe_clk (8 MHz) and its synchronous safe_reset.
- Each of NUM_CH channels divides safe_clk by a runtime-programmable ratio.
- Each channel produces a one-cycle tick and a selectable output: square wave or pulse train. Outputs drive LEDs/PMOD pins or enable internal logic.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 24, width of each channel's divide value and down-counter (2..32).

Ports:
- safe_clk  input  1  MMCM-derived clock; sole clock of the block.
- safe_reset  input  1  synchronous, active-high reset, sampled on rising edge of safe_clk.
- en  input  NUM_CH  per-channel count enable.
- mode  input  NUM_CH  per-channel output select: 0 = square (toggle), 1 = pulse.
- sync  input  1  restarts all channels in phase.
- div  input  NUM_CH*CNT_W  packed divide values; channel k uses div[k*CNT_W +: CNT_W]; period = div+1 cycles.
- tick  output  NUM_CH  one-cycle strobe per channel event, registered.
- ex_count_out  output  NUM_CH  per-channel output, registered, selected by mode.

Behaviour:
- All state registered on the rising edge of safe_clk. Per channel: cnt[CNT_W], div_l[CNT_W] (latched divide), tog, tick_r.
- Priority per edge: safe_reset > sync > en.
- safe_reset=1:
  - cnt <= div_k and div_l <= div_k, both sampled at that edge.
  - tog <= 0, tick <= 0, ex_count_out <= 0.
- sync=1 (not in reset), all channels regardless of en:
  - cnt <= div_k and div_l <= div_k.
  - tog <= 0, tick <= 0.
- en_k=0: cnt, div_l and tog hold; tick_k <= 0.
- en_k=1, cnt != 0: cnt <= cnt-1; tick_k <= 0.
- en_k=1, cnt == 0 (event):
  - cnt <= div_k (fresh sample); div_l <= div_k.
  - tick_k <= 1 for exactly one cycle; tog <= ~tog.
- Divide-value changes take effect only at the next event or sync. The current period is never truncated or extended (glitch-free retune).
- Latency: from reset release with en=1 and div=D, the first tick is high in the cycle after the (D+1)-th enabled edge. Subsequent ticks follow every D+1 enabled edges.
- div=0: event every enabled cycle. tick is constantly 1; tog toggles every cycle (safe_clk/2).
- Square period is 2*(D+1) cycles at 50% duty.
- ex_count_out_k = mode_k ? tick_k : tog_k. The mux is combinational on registered signals, so a mode change is visible the same cycle.
- Counter arithmetic is unsigned. cnt never underflows because reload happens at 0. div=all-ones is legal: period is 2^CNT_W cycles.
- Channels are fully independent except for the shared safe_reset and sync.
- Reset or sync mid-period aborts the period: no partial tick, square output forced low.

Test Plan:
- Reset then NUM_CH=4, CNT_W=8, div={3,0,9,255}, en=4'b1111, mode=0 -> ch0 tick after enabled edges 4,8,12; ch0 square period 8. ch1 tick constant 1, square toggles every cycle. ch2 tick every 10 cycles. ch3 tick every 256 cycles.
- ch0 div=3, mode=1; change div to 1 two cycles after a tick -> next tick still 4 cycles after previous; following ticks every 2 cycles.
- ch0 div=5; deassert en for 7 cycles mid-period -> tick is 0 during the gap, cnt frozen; period resumes and the tick arrives 7 cycles late. Square level holds through the gap.
- Channels with different divs running; pulse sync for 1 cycle -> all ticks and square outputs 0 the next cycle. Each channel's next tick comes after div_k+1 edges from sync, all in phase.
- Assert safe_reset for 1 cycle mid-period with en=1 -> all outputs 0 the next cycle; first tick exactly div+1 edges after release.
- Simultaneous sync and en=0 on ch2 -> ch2 reloads, tog=0; stays frozen until en returns, then ticks div+1 edges later.

Source files
------------

// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of independent programmable clock dividers on safe_clk.
// Each channel counts down from its divide value and emits a one-cycle tick
// at terminal count, plus either a 50% square wave or the tick as its output.
// A shared sync input restarts every channel in phase.
module clk_div_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 24
) (
  input  logic                      safe_clk,
  input  logic                      safe_reset,
  input  logic [NUM_CH-1:0]         en,
  input  logic [NUM_CH-1:0]         mode,
  input  logic                      sync,
  input  logic [NUM_CH*CNT_W-1:0]   div,
  output logic [NUM_CH-1:0]         tick,
  output logic [NUM_CH-1:0]         ex_count_out
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_div_k;
    logic             r_tog;
    logic             r_tick;
    logic             w_tog_nxt;
    logic             w_tick_nxt;
    logic             w_event;

    // The reload value is sampled from div only at an event, sync or reset,
    // so a retune never shortens or stretches the period already in flight.
    assign w_div_k = div[k*CNT_W +: CNT_W];
    assign w_event = en[k] && (r_cnt == '0);

    // Next-state: sync restarts the channel, otherwise count down while enabled.
    always_comb begin
      w_cnt_nxt  = r_cnt;
      w_tog_nxt  = r_tog;
      w_tick_nxt = 1'b0;
      if (sync) begin
        w_cnt_nxt = w_div_k;
        w_tog_nxt = 1'b0;
      end else if (w_event) begin
        w_cnt_nxt  = w_div_k;
        w_tick_nxt = 1'b1;
        w_tog_nxt  = ~r_tog;
      end else if (en[k]) begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
      end
    end

    // Channel state register; reset preloads the counter with the current div.
    always_ff @(posedge safe_clk) begin
      if (safe_reset) begin
        r_cnt  <= w_div_k;
        r_tog  <= 1'b0;
        r_tick <= 1'b0;
      end else begin
        r_cnt  <= w_cnt_nxt;
        r_tog  <= w_tog_nxt;
        r_tick <= w_tick_nxt;
      end
    end

    // Output select is a plain mux on registered bits, so it is glitch-free
    // and a mode change shows up in the same cycle.
    assign tick[k]         = r_tick;
    assign ex_count_out[k] = mode[k] ? r_tick : r_tog;
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank (NUM_CH=4, CNT_W=8). The stimulus pushes the
// hand-computed cycle numbers of every expected tick per channel; a monitor on
// the falling edge pops and compares whenever an expected tick is due or a
// tick appears.
module tb_clk_div_bank;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic                    safe_clk = 1'b0;
  logic                    safe_reset;
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH-1:0]       mode;
  logic                    sync;
  logic [NUM_CH*CNT_W-1:0] div;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       ex_count_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_q [NUM_CH][$];

  clk_div_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .safe_clk    (safe_clk),
    .safe_reset  (safe_reset),
    .en          (en),
    .mode        (mode),
    .sync        (sync),
    .div         (div),
    .tick        (tick),
    .ex_count_out(ex_count_out)
  );

  always #5 safe_clk = ~safe_clk;

  // cyc = number of rising edges seen so far
  always @(posedge safe_clk) cyc <= cyc + 1;

  // monitor: each due expectation must see a tick, any other tick is spurious
  always @(negedge safe_clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (exp_q[k].size() != 0 && exp_q[k][0] == cyc) begin
        void'(exp_q[k].pop_front());
        total++;
        if (tick[k] !== 1'b1) begin
          bad++;
          $display("FAIL missing_tick ch%0d cyc=%0d got=%b want=1", k, cyc, tick[k]);
        end
      end else if (tick[k] !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL spurious_tick ch%0d cyc=%0d got=%b want=0", k, cyc, tick[k]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge safe_clk);
    #1;
  endtask

  task automatic check(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
    end
  endtask

  task automatic push_ticks(input int ch, input int first, input int period, input int last);
    for (int c = first; c <= last; c += period) exp_q[ch].push_back(c);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < NUM_CH; k++) begin
      total++;
      if (exp_q[k].size() != 0) begin
        bad++;
        $display("FAIL %s ch%0d leftover=%0d want=0", name, k, exp_q[k].size());
        exp_q[k].delete();
      end
    end
  endtask

  task automatic set_div(input int ch, input int val);
    div[ch*CNT_W +: CNT_W] = CNT_W'(val);
  endtask

  task automatic check_all_zero(input string name);
    for (int k = 0; k < NUM_CH; k++) begin
      check({name, "_tick"}, tick[k], 1'b0);
      check({name, "_out"}, ex_count_out[k], 1'b0);
    end
  endtask

  initial begin
    int r, t1, t2, t3, t4, t5, t6;
    safe_reset = 1'b1;
    en   = '0;
    mode = '0;
    sync = 1'b0;
    div  = '0;
    set_div(0, 3); set_div(1, 0); set_div(2, 9); set_div(3, 255);

    // reset, then free run with div={3,0,9,255}
    step(3);
    check_all_zero("reset");
    r = cyc;
    safe_reset = 1'b0;
    en = 4'b1111;
    t1 = r + 520;
    push_ticks(0, r + 4, 4, t1);
    push_ticks(1, r + 1, 1, t1);
    push_ticks(2, r + 10, 10, t1);
    push_ticks(3, r + 256, 256, t1);
    step(4);
    check("sq0_hi", ex_count_out[0], 1'b1);
    check("sq1_lo", ex_count_out[1], 1'b0);
    step(1);
    check("sq1_hi", ex_count_out[1], 1'b1);
    step(3);
    check("sq0_lo", ex_count_out[0], 1'b0);
    step(1);
    check("sq2_lo", ex_count_out[2], 1'b0);
    step(1);
    check("sq2_hi", ex_count_out[2], 1'b1);
    step(t1 - cyc);
    drain("freerun");

    // pulse mode on ch0, retune 3 -> 1 two cycles after a tick
    en   = 4'b0001;
    mode = 4'b0001;
    #1;
    check("mode_same_cycle", ex_count_out[0], 1'b1);
    t2 = t1 + 10;
    push_ticks(0, t1 + 4, 2, t2);
    step(2);
    set_div(0, 1);
    step(1);
    check("pulse_lo", ex_count_out[0], 1'b0);
    step(t2 - cyc);
    drain("retune");

    // div=5, enable gap of 7 cycles mid-period
    mode = 4'b0000;
    set_div(0, 5);
    t3 = t2 + 22;
    exp_q[0].push_back(t2 + 2);
    exp_q[0].push_back(t2 + 15);
    exp_q[0].push_back(t2 + 21);
    step(4);
    en = 4'b0000;
    step(4);
    check("gap_tick", tick[0], 1'b0);
    check("gap_sq_hold", ex_count_out[0], 1'b1);
    step(3);
    en = 4'b0001;
    step(t3 - cyc);
    drain("en_gap");

    // sync pulse with ch0 square high mid-period
    check("pre_sync_sq", ex_count_out[0], 1'b1);
    set_div(0, 2); set_div(1, 4); set_div(2, 6); set_div(3, 1);
    en   = 4'b1111;
    sync = 1'b1;
    t4 = t3 + 13;
    push_ticks(0, t3 + 4, 3, t4);
    push_ticks(1, t3 + 6, 5, t4);
    push_ticks(2, t3 + 8, 7, t4);
    push_ticks(3, t3 + 3, 2, t4);
    step(1);
    sync = 1'b0;
    check_all_zero("sync");
    step(t4 - cyc);
    drain("sync");

    // one-cycle reset mid-period
    safe_reset = 1'b1;
    t5 = t4 + 11;
    push_ticks(0, t4 + 4, 3, t5);
    push_ticks(1, t4 + 6, 5, t5);
    push_ticks(2, t4 + 8, 7, t5);
    push_ticks(3, t4 + 3, 2, t5);
    step(1);
    safe_reset = 1'b0;
    check_all_zero("midreset");
    step(t5 - cyc);
    drain("midreset");

    // sync together with en=0 on ch2
    sync = 1'b1;
    en   = 4'b1011;
    t6 = t5 + 14;
    push_ticks(0, t5 + 4, 3, t6);
    push_ticks(1, t5 + 6, 5, t6);
    exp_q[2].push_back(t5 + 12);
    push_ticks(3, t5 + 3, 2, t6);
    step(1);
    sync = 1'b0;
    check_all_zero("sync_en0");
    step(3);
    check("frozen_sq2", ex_count_out[2], 1'b0);
    step(1);
    en = 4'b1111;
    step(7);
    check("resume_sq2", ex_count_out[2], 1'b1);
    step(t6 - cyc);
    drain("sync_en0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
